// File: rtl/hazard_ctrl.sv
// Pipeline hazard controller: load-use stall, branch flush, multi-cycle mul/div wait with timeout.
// Optional performance counters are built only when HAZARD_PERF_CNT_EN is defined.
module hazard_ctrl #(
  parameter int REG_ADDR_W = 4,
  parameter int MD_TIMEOUT = 32
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  IDEX_MemRead,
  input  logic [REG_ADDR_W-1:0] IDEX_RT,
  input  logic [REG_ADDR_W-1:0] IFID_RS,
  input  logic [REG_ADDR_W-1:0] IFID_RT,
  input  logic                  branch_taken,
  input  logic                  md_start,
  input  logic                  md_done,
  output logic                  pc_write,
  output logic                  ifid_write,
  output logic                  idex_write,
  output logic                  ifid_flush,
  output logic                  IDEX_FLUSH,
  output logic                  md_timeout,
  output logic [15:0]           stall_cnt,
  output logic [15:0]           flush_cnt
);

  localparam logic ST_RUN     = 1'b0;
  localparam logic ST_MD_WAIT = 1'b1;

  // Abort fires in the wait cycle whose increment would bring the counter to MD_TIMEOUT-1.
  localparam logic [5:0] TO_LAST = 6'(MD_TIMEOUT - 2);

  logic       state_q, state_d;
  logic [5:0] to_cnt_q, to_cnt_d;
  logic       load_use;

  assign load_use = IDEX_MemRead && ((IDEX_RT == IFID_RS) || (IDEX_RT == IFID_RT));

  always_comb begin
    pc_write   = 1'b1;
    ifid_write = 1'b1;
    idex_write = 1'b1;
    ifid_flush = 1'b0;
    IDEX_FLUSH = 1'b0;
    md_timeout = 1'b0;
    state_d    = state_q;
    to_cnt_d   = to_cnt_q;
    if (rst) begin
      case (state_q)
        ST_RUN: begin
          if (branch_taken) begin
            ifid_flush = 1'b1;
            IDEX_FLUSH = 1'b1;
          end else if (md_start) begin
            pc_write   = 1'b0;
            ifid_write = 1'b0;
            idex_write = 1'b0;
            state_d    = ST_MD_WAIT;
            to_cnt_d   = 6'd0;
          end else if (load_use) begin
            pc_write   = 1'b0;
            ifid_write = 1'b0;
            IDEX_FLUSH = 1'b1;
          end
        end
        ST_MD_WAIT: begin
          pc_write   = 1'b0;
          ifid_write = 1'b0;
          idex_write = 1'b0;
          if (md_done) begin
            state_d = ST_RUN;
          end else begin
            to_cnt_d = 6'(to_cnt_q + 6'd1);
            if (to_cnt_q == TO_LAST) begin
              md_timeout = 1'b1;
              IDEX_FLUSH = 1'b1;
              state_d    = ST_RUN;
            end
          end
        end
        default: state_d = ST_RUN;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q  <= ST_RUN;
      to_cnt_q <= 6'd0;
    end else begin
      state_q  <= state_d;
      to_cnt_q <= to_cnt_d;
    end
  end

`ifdef HAZARD_PERF_CNT_EN
  function automatic logic [15:0] sat_inc(input logic [15:0] v);
    return (v == 16'hFFFF) ? v : 16'(v + 16'd1);
  endfunction

  logic [15:0] stall_cnt_q, stall_cnt_d;
  logic [15:0] flush_cnt_q, flush_cnt_d;

  always_comb begin
    stall_cnt_d = stall_cnt_q;
    flush_cnt_d = flush_cnt_q;
    if (!pc_write)               stall_cnt_d = sat_inc(stall_cnt_q);
    if (ifid_flush || IDEX_FLUSH) flush_cnt_d = sat_inc(flush_cnt_q);
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      stall_cnt_q <= 16'h0000;
      flush_cnt_q <= 16'h0000;
    end else begin
      stall_cnt_q <= stall_cnt_d;
      flush_cnt_q <= flush_cnt_d;
    end
  end

  assign stall_cnt = stall_cnt_q;
  assign flush_cnt = flush_cnt_q;
`else
  assign stall_cnt = 16'h0000;
  assign flush_cnt = 16'h0000;
`endif

endmodule

// File: tb/tb_hazard_ctrl.sv
// Scoreboard bench for hazard_ctrl: directed vectors push expected outputs, a monitor pops and compares.
module tb_hazard_ctrl;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        IDEX_MemRead = 1'b0;
  logic [3:0]  IDEX_RT = '0, IFID_RS = '0, IFID_RT = '0;
  logic        branch_taken = 1'b0, md_start = 1'b0, md_done = 1'b0;
  logic        pc_write, ifid_write, idex_write, ifid_flush, IDEX_FLUSH, md_timeout;
  logic [15:0] stall_cnt, flush_cnt;

  always #5 clk = ~clk;

  hazard_ctrl #(.REG_ADDR_W(4), .MD_TIMEOUT(32)) dut (
    .clk(clk), .rst(rst),
    .IDEX_MemRead(IDEX_MemRead), .IDEX_RT(IDEX_RT), .IFID_RS(IFID_RS), .IFID_RT(IFID_RT),
    .branch_taken(branch_taken), .md_start(md_start), .md_done(md_done),
    .pc_write(pc_write), .ifid_write(ifid_write), .idex_write(idex_write),
    .ifid_flush(ifid_flush), .IDEX_FLUSH(IDEX_FLUSH), .md_timeout(md_timeout),
    .stall_cnt(stall_cnt), .flush_cnt(flush_cnt)
  );

  // Expected output bits: {pc_write, ifid_write, idex_write, ifid_flush, IDEX_FLUSH, md_timeout}
  localparam logic [5:0] E_RUN = 6'b111000;
  localparam logic [5:0] E_STL = 6'b000000;
  localparam logic [5:0] E_LU  = 6'b001010;
  localparam logic [5:0] E_BR  = 6'b111110;
  localparam logic [5:0] E_TO  = 6'b000011;

  typedef struct {
    logic       rst, mr;
    logic [3:0] idrt, rs, rt;
    logic       br, ms, md;
    logic [5:0] exp;
    string      nm;
  } vec_t;

  typedef struct {
    logic       rst;
    logic [5:0] exp;
    string      nm;
  } exp_t;

  vec_t stim_q[$];
  exp_t sb_q[$];
  int   errors = 0;
  int   checks = 0;

  task automatic add(input logic r, input logic mr, input logic [3:0] a, input logic [3:0] b,
                     input logic [3:0] c, input logic br, input logic ms, input logic md,
                     input logic [5:0] e, input string nm);
    vec_t v;
    v.rst = r; v.mr = mr; v.idrt = a; v.rs = b; v.rt = c;
    v.br = br; v.ms = ms; v.md = md; v.exp = e; v.nm = nm;
    stim_q.push_back(v);
  endtask

  task automatic idle(input string nm);
    add(1, 0, 0, 0, 0, 0, 0, 0, E_RUN, nm);
  endtask

  // Monitor: compares outputs and a counter model built from the expected outputs only.
  initial begin
    exp_t        e;
    logic [5:0]  got;
    logic [15:0] st_m = 16'h0, fl_m = 16'h0;
    logic [15:0] st_x, fl_x;
    forever begin
      @(negedge clk);
      if (sb_q.size() > 0) begin
        e = sb_q.pop_front();
        got = {pc_write, ifid_write, idex_write, ifid_flush, IDEX_FLUSH, md_timeout};
        checks++;
        if (got !== e.exp) begin
          errors++;
          $display("FAIL %s: outputs=%b expected=%b", e.nm, got, e.exp);
        end
        if (!e.rst) begin
          st_m = 16'h0;
          fl_m = 16'h0;
        end
`ifdef HAZARD_PERF_CNT_EN
        st_x = st_m; fl_x = fl_m;
`else
        st_x = 16'h0; fl_x = 16'h0;
`endif
        checks++;
        if (stall_cnt !== st_x || flush_cnt !== fl_x) begin
          errors++;
          $display("FAIL %s_cnt: stall=%0d flush=%0d expected stall=%0d flush=%0d",
                   e.nm, stall_cnt, flush_cnt, st_x, fl_x);
        end
        if (e.rst) begin
          if (!e.exp[5])              st_m = st_m + 16'd1;
          if (e.exp[2] || e.exp[1])   fl_m = fl_m + 16'd1;
        end
      end
    end
  end

  initial begin
    // Reset held with busy inputs: defaults regardless
    add(0, 1, 4, 4, 0, 1, 1, 0, E_RUN, "rst_busy");
    add(0, 1, 4, 4, 0, 0, 1, 0, E_RUN, "rst_busy2");
    idle("idle0");
    idle("idle1");
    // Load-use on RS, exactly one bubble
    add(1, 1, 4, 4, 0, 0, 0, 0, E_LU, "lu_rs");
    idle("after_lu_rs");
    // Load-use on RT
    add(1, 1, 7, 2, 7, 0, 0, 0, E_LU, "lu_rt");
    idle("after_lu_rt");
    // Near misses
    add(1, 1, 5, 4, 6, 0, 0, 0, E_RUN, "no_match");
    add(1, 0, 4, 4, 4, 0, 0, 0, E_RUN, "no_memread");
    // Branch beats md_start and load-use
    add(1, 1, 3, 3, 3, 1, 1, 0, E_BR, "br_prio");
    idle("after_br");
    add(1, 0, 0, 0, 0, 0, 0, 1, E_RUN, "done_in_run");
    // md_start beats load-use, done after 5 wait cycles; hazards ignored while waiting
    add(1, 1, 9, 9, 0, 0, 1, 0, E_STL, "md_start");
    for (int i = 0; i < 4; i++) add(1, 1, 9, 9, 9, 1, 1, 0, E_STL, "md_wait");
    add(1, 0, 0, 0, 0, 0, 0, 1, E_STL, "md_done");
    idle("after_done");
    // Timeout: abort in the 32nd stall cycle
    add(1, 0, 0, 0, 0, 0, 1, 0, E_STL, "to_start");
    for (int i = 0; i < 30; i++) add(1, 0, 0, 0, 0, 0, 0, 0, E_STL, "to_wait");
    add(1, 0, 0, 0, 0, 0, 0, 0, E_TO, "to_fire");
    idle("after_to");
    // md_done on the expiry cycle wins
    add(1, 0, 0, 0, 0, 0, 1, 0, E_STL, "tie_start");
    for (int i = 0; i < 30; i++) add(1, 0, 0, 0, 0, 0, 0, 0, E_STL, "tie_wait");
    add(1, 0, 0, 0, 0, 0, 0, 1, E_STL, "tie_done");
    idle("after_tie");
    // Reset mid-wait abandons it
    add(1, 0, 0, 0, 0, 0, 1, 0, E_STL, "rw_start");
    for (int i = 0; i < 3; i++) add(1, 0, 0, 0, 0, 0, 0, 0, E_STL, "rw_wait");
    add(0, 1, 2, 2, 0, 0, 1, 0, E_RUN, "rw_rst");
    add(0, 0, 0, 0, 0, 1, 0, 0, E_RUN, "rw_rst2");
    add(0, 0, 0, 0, 0, 0, 0, 0, E_RUN, "rw_rst3");
    idle("rw_release");
    add(1, 1, 1, 0, 1, 0, 0, 0, E_LU, "lu_post_rst");
    idle("final");

    foreach (stim_q[i]) begin
      exp_t x;
      @(posedge clk);
      #1;
      rst          = stim_q[i].rst;
      IDEX_MemRead = stim_q[i].mr;
      IDEX_RT      = stim_q[i].idrt;
      IFID_RS      = stim_q[i].rs;
      IFID_RT      = stim_q[i].rt;
      branch_taken = stim_q[i].br;
      md_start     = stim_q[i].ms;
      md_done      = stim_q[i].md;
      x.rst = stim_q[i].rst; x.exp = stim_q[i].exp; x.nm = stim_q[i].nm;
      sb_q.push_back(x);
    end

    for (int i = 0; i < 10 && sb_q.size() > 0; i++) @(negedge clk);
    #1;
    if (sb_q.size() != 0) begin
      errors++;
      $display("FAIL drain: pending=%0d expected=0", sb_q.size());
    end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/hazard_ctrl.md
HAZARD_CTRL -- requirements
Module: hazard_ctrl

Interface
REQ-001 Parameter REG_ADDR_W, default 4: register-specifier width.
REQ-002 Parameter MD_TIMEOUT, default 32: maximum mul/div wait cycles before abort; legal range 2..63.
REQ-003 clk  input  1  sole clock; all state updates on rising edge.
REQ-004 rst  input  1  asynchronous, active-low reset.
REQ-005 IDEX_MemRead  input  1  instruction in ID/EX is a load.
REQ-006 IDEX_RT  input  REG_ADDR_W  destination register of the ID/EX instruction.
REQ-007 IFID_RS, IFID_RT  input  REG_ADDR_W each  source registers of the IF/ID instruction.
REQ-008 branch_taken  input  1  branch resolved taken in EX this cycle.
REQ-009 md_start  input  1  ID/EX holds a multi-cycle mul/div this cycle.
REQ-010 md_done  input  1  mul/div unit result valid; single-cycle pulse.
REQ-011 pc_write, ifid_write, idex_write  output  1 each  stage-register enables.
REQ-012 ifid_flush, IDEX_FLUSH  output  1 each  bubble-insert controls.
REQ-013 md_timeout  output  1  one-cycle pulse on mul/div abort.
REQ-014 stall_cnt, flush_cnt  output  16 each  performance counters (see Configuration).

Function
REQ-015 FSM states: RUN, MD_WAIT; encoding implementer's choice.
REQ-016 RUN defaults: pc_write=ifid_write=idex_write=1, ifid_flush=IDEX_FLUSH=0.
REQ-017 Priority in RUN, evaluated combinationally same cycle: branch_taken > md_start > load-use.
REQ-018 branch_taken in RUN: ifid_flush=1, IDEX_FLUSH=1, pc_write=1 (target load); state stays RUN.
REQ-019 md_start without branch_taken in RUN: pc_write=ifid_write=idex_write=0 this cycle; next state MD_WAIT; timeout counter loads 0.
REQ-020 Load-use = IDEX_MemRead and (IDEX_RT==IFID_RS or IDEX_RT==IFID_RT); with no branch_taken and no md_start: pc_write=0, ifid_write=0, IDEX_FLUSH=1; state stays RUN; exactly one bubble per hazard.
REQ-021 MD_WAIT: pc_write=ifid_write=idex_write=0, both flushes 0; branch_taken, md_start and load-use ignored.
REQ-022 MD_WAIT with md_done=1: enables stay 0 that cycle; next state RUN.
REQ-023 Timeout counter (6 bits) increments each MD_WAIT cycle without md_done; reaching MD_TIMEOUT-1 without md_done: md_timeout=1 that cycle, IDEX_FLUSH=1, next state RUN.
REQ-024 md_done and timeout expiry in the same cycle: md_done wins, md_timeout stays 0.
REQ-025 md_done while in RUN: ignored, no output effect.
REQ-026 All outputs are functions of current state, counter and current inputs only; no extra latency beyond REQ-019/022/023.

Reset
REQ-027 rst low asynchronously forces state RUN, timeout counter 0, md_timeout 0, stall_cnt 0, flush_cnt 0.
REQ-028 While rst low, stage-enable and flush outputs take RUN defaults (REQ-016) regardless of inputs.
REQ-029 rst asserted mid-MD_WAIT abandons the wait without md_timeout; first cycle after release is RUN.

Configuration
REQ-030 Macro HAZARD_PERF_CNT_EN defined: stall_cnt counts cycles with pc_write=0; flush_cnt counts cycles with ifid_flush=1 or IDEX_FLUSH=1; both 16-bit, saturate at 16'hFFFF, cleared only by rst.
REQ-031 HAZARD_PERF_CNT_EN undefined: no counter registers; stall_cnt and flush_cnt tied to 16'h0000; ports retained.

Verification
REQ-032 Release rst, idle inputs -> pc_write=ifid_write=idex_write=1, all flushes 0, counters 0.
REQ-033 IDEX_MemRead=1, IDEX_RT=4, IFID_RS=4 for one cycle -> pc_write=0, ifid_write=0, IDEX_FLUSH=1 that cycle only; stall_cnt=1 (macro on).
REQ-034 branch_taken=1 together with load-use and md_start -> ifid_flush=IDEX_FLUSH=1, pc_write=1, state remains RUN.
REQ-035 md_start pulse, md_done 5 cycles later -> enables 0 for 6 cycles total, enables 1 from following cycle, md_timeout never 1.
REQ-036 md_start, no md_done, MD_TIMEOUT=32 -> md_timeout and IDEX_FLUSH pulse in 32nd stall cycle, RUN next cycle.
REQ-037 rst low 3 cycles into MD_WAIT -> immediate RUN defaults, counters 0, no md_timeout; macro off -> stall_cnt=flush_cnt=0 throughout.
